branch_compare_seq: RTL

- Iterative, parametrised magnitude/equality comparator for the multi-cycle RISC-V core's branch path.
- Compares two WIDTH-bit operands CHUNK bits per cycle, starting at the MSB chunk. Terminates early on the first differing chunk.
- Honours signed/unsigned mode from the branch funct3 and produces lt/eq/gt plus a branch-taken flag.
- Valid/ready handshakes on both input and result sides; sits between register-read and PC-select.

---
 rtl/branch_cmp_pkg.sv | 46 ++++
 rtl/branch_compare_seq_chunk_cmp.sv | 22 ++
 rtl/branch_compare_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/branch_cmp_pkg.sv
// Shared definitions for the iterative branch comparator: funct3 encodings,
// FSM state type, result record and the funct3 decode helpers.
package branch_cmp_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
    logic taken;
  } cmp_result_t;

  function automatic logic is_signed_f3(input logic [2:0] f3);
    return (f3 == F3_BLT) || (f3 == F3_BGE);
  endfunction

  // Non-branch encodings (010/011) still report lt/eq/gt but never take.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       lt,
                                        input logic       eq);
    logic t;
    case (f3)
      F3_BEQ:  t = eq;
      F3_BNE:  t = !eq;
      F3_BLT:  t = lt;
      F3_BGE:  t = !lt;
      F3_BLTU: t = lt;
      F3_BGEU: t = !lt;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_compare_seq_chunk_cmp.sv
// Combinational compare of one CHUNK-bit slice; signed_en selects a
// two's-complement compare (used only for the most significant slice).
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             signed_en,
  output logic             c_lt,
  output logic             c_eq
);

  always_comb begin
    c_eq = (x == y);
    if (signed_en) begin
      c_lt = $signed(x) < $signed(y);
    end else begin
      c_lt = x < y;
    end
  end

endmodule

// File: rtl/branch_compare_seq.sv
// Iterative MSB-first magnitude/equality comparator for the branch path.
// Scans one CHUNK per cycle and stops at the first differing chunk.
module branch_compare_seq
  import branch_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       funct3,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             taken,
  output logic             busy,
  output cmp_state_t       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NCHUNK - 1);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
    $error("branch_compare_seq: WIDTH must be a positive multiple of CHUNK");
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // start side is ready only in IDLE; result stays valid in DONE until taken.
  cmp_state_t       state_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       f3_q;
  cmp_result_t      res_q;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CHUNK-1:0] x_chunk;
  logic [CHUNK-1:0] y_chunk;
  logic             signed_en;
  logic             c_lt;
  logic             c_eq;

  // One comparator, fed by shifting the selected chunk down to bit 0.
  always_comb begin
    a_sh      = a_q >> (idx_q * CHUNK);
    b_sh      = b_q >> (idx_q * CHUNK);
    x_chunk   = a_sh[CHUNK-1:0];
    y_chunk   = b_sh[CHUNK-1:0];
    signed_en = is_signed_f3(f3_q) && (idx_q == TOP_IDX);
  end

  chunk_cmp #(
    .CHUNK(CHUNK)
  ) u_chunk_cmp (
    .x        (x_chunk),
    .y        (y_chunk),
    .signed_en(signed_en),
    .c_lt     (c_lt),
    .c_eq     (c_eq)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= TOP_IDX;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q     <= a;
            b_q     <= b;
            f3_q    <= funct3;
            res_q   <= '0;
            idx_q   <= TOP_IDX;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (!c_eq) begin
            res_q.lt    <= c_lt;
            res_q.eq    <= 1'b0;
            res_q.gt    <= !c_lt;
            res_q.taken <= branch_taken(f3_q, c_lt, 1'b0);
            state_q     <= DONE;
          end else if (idx_q == '0) begin
            res_q.lt    <= 1'b0;
            res_q.eq    <= 1'b1;
            res_q.gt    <= 1'b0;
            res_q.taken <= branch_taken(f3_q, 1'b0, 1'b1);
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          if (result_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    start_ready  = (state_q == IDLE) && !reset;
    result_valid = (state_q == DONE);
    busy         = (state_q != IDLE);
    lt           = res_q.lt;
    eq           = res_q.eq;
    gt           = res_q.gt;
    taken        = res_q.taken;
    dbg_state    = state_q;
  end

endmodule
